// File: rtl/i8088_bus_pkg.sv
// Shared types for the 8088 bus controller: region descriptors, FSM states
// and the default four-region decode table.
package i8088_bus_pkg;

   localparam int MAX_REGIONS = 16;

   typedef struct packed {
      logic        iom;
      logic [19:0] base;
      logic [19:0] mask;
      logic [3:0]  waits;
   } region_t;

   typedef region_t [0:MAX_REGIONS-1] region_tab_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Entries beyond NREG are never consulted by the decoder.
   function automatic region_tab_t default_regions();
      region_tab_t t;
      t    = '0;
      t[0] = '{iom: 1'b0, base: 20'h00000, mask: 20'h80000, waits: 4'd0};
      t[1] = '{iom: 1'b0, base: 20'h80000, mask: 20'h80000, waits: 4'd2};
      t[2] = '{iom: 1'b1, base: 20'h00000, mask: 20'h10000, waits: 4'd1};
      t[3] = '{iom: 1'b1, base: 20'h10000, mask: 20'h10000, waits: 4'd3};
      return t;
   endfunction

   localparam region_tab_t DEFAULT_REGIONS = default_regions();

endpackage

// File: rtl/i8088_region_dec.sv
// Combinational region decoder: matches an address/IOM pair against the
// region table and returns a one-hot select for the lowest matching index.
module i8088_region_dec
   import i8088_bus_pkg::*;
#(
   parameter int          NREG    = 4,
   parameter region_tab_t REGIONS = DEFAULT_REGIONS
) (
   input  logic            iom,
   input  logic [19:0]     addr,
   output logic [NREG-1:0] cs,
   output logic            hit,
   output logic [3:0]      waits
);

   // Scanning from the top down lets the lowest matching index overwrite last.
   always_comb begin
      cs    = '0;
      hit   = 1'b0;
      waits = 4'd0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if ((REGIONS[i].iom == iom) &&
             ((addr & REGIONS[i].mask) == (REGIONS[i].base & REGIONS[i].mask))) begin
            cs    = '0;
            cs[i] = 1'b1;
            hit   = 1'b1;
            waits = REGIONS[i].waits;
         end
      end
   end

endmodule

// File: rtl/i8088_bus_ctrl.sv
// 8088 bus controller: latches the address on a rising ALE, drives a registered
// one-hot chip select and inserts per-region wait states via READY.
module i8088_bus_ctrl
   import i8088_bus_pkg::*;
#(
   parameter int          NREG    = 4,
   parameter region_tab_t REGIONS = DEFAULT_REGIONS
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            ALE,
   input  logic            IOM,
   input  logic            RD,
   input  logic            WR,
   input  logic [11:0]     A,
   input  logic [7:0]      AD,
   output logic [19:0]     Address,
   output logic [NREG-1:0] CS,
   output logic            READY,
   output logic            BUS_ERR,
   output state_t          fsm_state
);

   state_t          state, state_n;
   logic [19:0]     addr_n;
   logic [NREG-1:0] cs_n;
   logic            ready_n, bus_err_n;
   logic            iom_q, iom_n;
   logic            ale_q;
   logic            hit_q, hit_n;
   logic [3:0]      waits_q, waits_n;
   logic [3:0]      cnt, cnt_n;

   logic [NREG-1:0] dec_cs;
   logic            dec_hit;
   logic [3:0]      dec_waits;
   logic            ale_rise;
   logic            strobe;

   // Decode straight from the pins so CS is valid the cycle after ALE.
   i8088_region_dec #(
      .NREG    (NREG),
      .REGIONS (REGIONS)
   ) u_dec (
      .iom   (IOM),
      .addr  ({A, AD}),
      .cs    (dec_cs),
      .hit   (dec_hit),
      .waits (dec_waits)
   );

   assign ale_rise  = ALE && !ale_q;
   assign strobe    = !RD || !WR;
   assign fsm_state = state;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         Address <= '0;
         CS      <= '0;
         READY   <= 1'b1;
         BUS_ERR <= 1'b0;
         cnt     <= '0;
         iom_q   <= 1'b0;
         ale_q   <= 1'b0;
         hit_q   <= 1'b0;
         waits_q <= '0;
      end else begin
         state   <= state_n;
         Address <= addr_n;
         CS      <= cs_n;
         READY   <= ready_n;
         BUS_ERR <= bus_err_n;
         cnt     <= cnt_n;
         iom_q   <= iom_n;
         ale_q   <= ALE;
         hit_q   <= hit_n;
         waits_q <= waits_n;
      end
   end

   always_comb begin
      state_n   = state;
      addr_n    = Address;
      cs_n      = CS;
      ready_n   = READY;
      bus_err_n = 1'b0;
      cnt_n     = cnt;
      iom_n     = iom_q;
      hit_n     = hit_q;
      waits_n   = waits_q;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (state == ST_DONE && RD && WR) begin
               state_n = ST_IDLE;
               cs_n    = '0;
            end
            // A fresh ALE edge takes precedence over the DONE release.
            if (ale_rise) begin
               addr_n  = {A, AD};
               iom_n   = IOM;
               cs_n    = dec_cs;
               hit_n   = dec_hit;
               waits_n = dec_waits;
               state_n = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (strobe) begin
               if (!hit_q) begin
                  bus_err_n = 1'b1;
                  state_n   = ST_DONE;
               end else if (waits_q == 4'd0) begin
                  state_n = ST_DONE;
               end else begin
                  ready_n = 1'b0;
                  cnt_n   = waits_q - 4'd1;
                  state_n = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!strobe) begin
               ready_n = 1'b1;
               cs_n    = '0;
               state_n = ST_IDLE;
            end else if (cnt == 4'd0) begin
               ready_n = 1'b1;
               state_n = ST_DONE;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_i8088_bus_ctrl.sv
// Bench for i8088_bus_ctrl: three instances (default table, two-region table,
// overlapping table) driven by shared pins and checked against a table model.
module tb_i8088_bus_ctrl;
   import i8088_bus_pkg::*;

   function automatic region_tab_t overlap_tab();
      region_tab_t t;
      t    = DEFAULT_REGIONS;
      t[1] = '{iom: 1'b0, base: 20'h00000, mask: 20'h00000, waits: 4'd1};
      return t;
   endfunction

   localparam region_tab_t OVL_TAB = overlap_tab();

   logic        CLK = 1'b0;
   logic        RESET, ALE, IOM, RD, WR;
   logic [11:0] A;
   logic [7:0]  AD;

   logic [19:0] addr0, addr1, addr2;
   logic [3:0]  cs0;
   logic [1:0]  cs1, cs2;
   logic        rdy0, rdy1, rdy2, be0, be1, be2;
   state_t      st0, st1, st2;

   int checks = 0;
   int errors = 0;
   int sel    = 0;
   logic [3:0] exp_q[$];

   logic [19:0] o_addr;
   logic [3:0]  o_cs;
   logic        o_ready, o_be;
   state_t      o_st;

   always #5 CLK = ~CLK;

   i8088_bus_ctrl u_def (
      .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .A(A), .AD(AD),
      .Address(addr0), .CS(cs0), .READY(rdy0), .BUS_ERR(be0), .fsm_state(st0));

   i8088_bus_ctrl #(.NREG(2)) u_two (
      .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .A(A), .AD(AD),
      .Address(addr1), .CS(cs1), .READY(rdy1), .BUS_ERR(be1), .fsm_state(st1));

   i8088_bus_ctrl #(.NREG(2), .REGIONS(OVL_TAB)) u_ovl (
      .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .A(A), .AD(AD),
      .Address(addr2), .CS(cs2), .READY(rdy2), .BUS_ERR(be2), .fsm_state(st2));

   always_comb begin
      o_addr  = addr0;
      o_cs    = cs0;
      o_ready = rdy0;
      o_be    = be0;
      o_st    = st0;
      case (sel)
         1: begin
            o_addr = addr1; o_cs = {2'b00, cs1}; o_ready = rdy1; o_be = be1; o_st = st1;
         end
         2: begin
            o_addr = addr2; o_cs = {2'b00, cs2}; o_ready = rdy2; o_be = be2; o_st = st2;
         end
         default: ;
      endcase
   end

   // Reference: first table entry (lowest index) whose masked bits agree wins.
   function automatic void model(input int s, input bit iom, input logic [19:0] addr,
                                 output logic [3:0] cs, output int w, output bit hit);
      region_tab_t t;
      int n;
      t   = (s == 2) ? OVL_TAB : DEFAULT_REGIONS;
      n   = (s == 0) ? 4 : 2;
      cs  = 4'd0;
      w   = 0;
      hit = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!hit && t[i].iom == iom && ((addr ^ t[i].base) & t[i].mask) == 20'd0) begin
            hit = 1'b1;
            cs  = 4'd1 << i;
            w   = int'(t[i].waits);
         end
      end
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_cycle(input bit iom, input logic [19:0] addr);
      ALE = 1'b1; IOM = iom; A = addr[19:8]; AD = addr[7:0];
      tick();
      ALE = 1'b0;
   endtask

   // kind: 0 read, 1 write, 2 both strobes together
   task automatic run_cycle(input int s, input bit iom, input logic [19:0] addr, input int kind);
      logic [3:0] ecs;
      logic [3:0] qcs;
      int w, low;
      bit hit, be_first;
      sel = s;
      model(s, iom, addr, ecs, w, hit);
      exp_q.push_back(ecs);
      start_cycle(iom, addr);
      qcs = exp_q.pop_front();
      checks++;
      if (o_addr !== addr) begin
         errors++; $display("FAIL addr_latch got=%h exp=%h", o_addr, addr);
      end
      checks++;
      if (o_cs !== qcs) begin
         errors++; $display("FAIL cs_after_ale addr=%h got=%b exp=%b", addr, o_cs, qcs);
      end
      RD = (kind == 1); WR = (kind == 0);
      tick();
      be_first = o_be;
      low = 0;
      while (o_ready === 1'b0 && low < 20) begin
         low++;
         tick();
      end
      checks++;
      if (low !== w) begin
         errors++; $display("FAIL wait_count addr=%h got=%0d exp=%0d", addr, low, w);
      end
      checks++;
      if (be_first !== !hit) begin
         errors++; $display("FAIL bus_err_pulse addr=%h got=%b exp=%b", addr, be_first, !hit);
      end
      tick();
      checks++;
      if (o_be !== 1'b0 || o_st !== ST_DONE || o_cs !== qcs || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL done_hold addr=%h be=%b st=%0d cs=%b rdy=%b exp be=0 st=%0d cs=%b rdy=1",
                  addr, o_be, o_st, o_cs, o_ready, ST_DONE, qcs);
      end
      RD = 1'b1; WR = 1'b1;
      tick();
      checks++;
      if (o_st !== ST_IDLE || o_cs !== 4'd0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL release addr=%h st=%0d cs=%b rdy=%b exp st=%0d cs=0000 rdy=1",
                  addr, o_st, o_cs, o_ready, ST_IDLE);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; ALE = 1'b1; RD = 1'b0; WR = 1'b0; IOM = 1'b0; A = 12'hFFF; AD = 8'hFF;
      tick(); tick();
      sel = 0;
      checks++;
      if (o_addr !== 20'd0 || o_cs !== 4'd0 || o_ready !== 1'b1 || o_be !== 1'b0 || o_st !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state addr=%h cs=%b rdy=%b be=%b st=%0d exp 00000/0000/1/0/%0d",
                  o_addr, o_cs, o_ready, o_be, o_st, ST_IDLE);
      end
      RESET = 1'b0; ALE = 1'b0; RD = 1'b1; WR = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      run_cycle(0, 1'b0, 20'h12345, 0);
      run_cycle(0, 1'b0, 20'h9ABCD, 1);
      run_cycle(0, 1'b1, 20'h001F0, 0);
      run_cycle(0, 1'b1, 20'h10000, 0);
      run_cycle(0, 1'b1, 20'h10000, 2);
   endtask

   task automatic test_unmapped();
      run_cycle(1, 1'b1, 20'h003F8, 0);
      run_cycle(1, 1'b0, 20'h80010, 1);
   endtask

   task automatic test_overlap();
      run_cycle(2, 1'b0, 20'h00100, 0);
      run_cycle(2, 1'b0, 20'h80100, 1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         run_cycle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   20'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_abort();
      sel = 0;
      start_cycle(1'b1, 20'h1ABCD);
      RD = 1'b0;
      tick(); tick();
      RD = 1'b1;
      tick();
      checks++;
      if (o_ready !== 1'b1 || o_cs !== 4'd0 || o_st !== ST_IDLE) begin
         errors++;
         $display("FAIL abort rdy=%b cs=%b st=%0d exp 1/0000/%0d", o_ready, o_cs, o_st, ST_IDLE);
      end
   endtask

   task automatic test_reset_mid_wait();
      sel = 0;
      start_cycle(1'b1, 20'h10080);
      RD = 1'b0;
      tick(); tick();
      checks++;
      if (o_ready !== 1'b0 || o_cs !== 4'b1000) begin
         errors++; $display("FAIL pre_reset_wait rdy=%b cs=%b exp 0/1000", o_ready, o_cs);
      end
      RESET = 1'b1;
      tick();
      checks++;
      if (o_ready !== 1'b1 || o_cs !== 4'd0 || o_addr !== 20'd0 || o_st !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_mid_wait rdy=%b cs=%b addr=%h st=%0d exp 1/0000/00000/%0d",
                  o_ready, o_cs, o_addr, o_st, ST_IDLE);
      end
      RESET = 1'b0; RD = 1'b1;
      tick();
      run_cycle(0, 1'b1, 20'h10080, 0);
   endtask

   task automatic test_ale_rules();
      sel = 0;
      ALE = 1'b1; IOM = 1'b0; A = 12'h123; AD = 8'h45;
      tick();
      ALE = 1'b0; tick();
      ALE = 1'b1; A = 12'hFED; AD = 8'hCB;
      tick();
      checks++;
      if (o_addr !== 20'h12345 || o_st !== ST_ADDR) begin
         errors++; $display("FAIL ale_in_addr addr=%h st=%0d exp 12345/%0d", o_addr, o_st, ST_ADDR);
      end
      // ALE stays high through the whole cycle: no restart once back in DONE/IDLE.
      WR = 1'b0;
      tick(); tick();
      WR = 1'b1;
      tick(); tick();
      checks++;
      if (o_st !== ST_IDLE || o_addr !== 20'h12345 || o_cs !== 4'd0) begin
         errors++;
         $display("FAIL ale_level_hold st=%0d addr=%h cs=%b exp %0d/12345/0000", o_st, o_addr, o_cs, ST_IDLE);
      end
      ALE = 1'b0;
      tick();
   endtask

   initial begin
      RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; A = '0; AD = '0;
      test_reset();
      test_directed();
      test_unmapped();
      test_overlap();
      test_abort();
      test_reset_mid_wait();
      test_ale_rules();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
